// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | riscv_fetch_pkg : shared fetch-front-end constants and entry type  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package riscv_fetch_pkg;

    localparam int unsigned             FETCH_XLEN     = 32;
    localparam logic [FETCH_XLEN-1:0]   FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0]             NOP_INSTR      = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic fetch_entry_t pack_entry(input logic [FETCH_XLEN-1:0] pc,
                                                input logic [FETCH_XLEN-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_prefetch_unit_if : redirect, imem and decode-side signals    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface fetch_prefetch_unit_if
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned XLEN = FETCH_XLEN
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pcplus4;

    // master is the fetch unit; slave is memory, EX and decode together
    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pcplus4
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pcplus4
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo : synchronous FIFO with clear, full/empty and count     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module fetch_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic      [CW-1:0]    count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             w_do_push, w_do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // a push onto a full FIFO is accepted only when the head leaves in the same cycle
    assign w_do_pop  = pop_i && !clear_i && (count_q != '0);
    assign w_do_push = push_i && !clear_i && ((count_q < CW'(DEPTH)) || w_do_pop);

    always_comb begin
        count_d = count_q;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (w_do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_prefetch_unit : credit-based prefetching IF stage with queue |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module fetch_prefetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input wire logic              clk,
    input wire logic              rst,
    fetch_prefetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned EW = 2 * XLEN;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [OW-1:0]   w_out_cnt, w_out_cnt_next, w_live;
    logic            w_tag_full, w_tag_empty;
    logic [XLEN-1:0] w_tag_pc;
    logic [CW-1:0]   w_q_count;
    logic            w_q_full, w_q_empty;
    logic [EW-1:0]   w_push_entry, w_head;
    logic            w_credit_ok, w_req_valid, w_accept;
    logic            w_rsp, w_drop, w_push, w_pop;

    // outstanding requests are exactly the PC tags not yet matched by a response
    assign w_out_cnt   = OW'(0) + w_out_cnt_raw();
    assign w_live      = w_out_cnt - drop_cnt_q;
    assign w_credit_ok = ({1'b0, w_q_count} + (CW+1)'(w_live)) < (CW+1)'(DEPTH);
    assign w_req_valid = !rst && !bus.redirect && !w_tag_full && w_credit_ok;
    assign w_accept    = w_req_valid && bus.imem_req_ready;
    assign w_rsp       = bus.imem_rsp_valid && !w_tag_empty;
    assign w_drop      = w_rsp && (drop_cnt_q != '0);
    assign w_push      = w_rsp && (drop_cnt_q == '0) && !bus.redirect && (!w_q_full || w_pop);
    assign w_pop       = !w_q_empty && bus.if_ready && !bus.redirect;

    assign w_out_cnt_next = w_out_cnt + OW'(w_accept) - OW'(w_rsp);

    logic [OW-1:0] w_tag_count;
    function automatic logic [OW-1:0] w_out_cnt_raw();
        return w_tag_count;
    endfunction

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect) begin
            pc_d       = {bus.redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_d = w_out_cnt_next;
        end else begin
            if (w_accept) pc_d = pc_q + XLEN'(4);
            if (w_drop)   drop_cnt_d = drop_cnt_q - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // tags survive a redirect so that stale responses still retire their own tag
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (1'b0),
        .push_i  (w_accept),
        .data_i  (pc_q),
        .pop_i   (w_rsp),
        .data_o  (w_tag_pc),
        .full_o  (w_tag_full),
        .empty_o (w_tag_empty),
        .count_o (w_tag_count)
    );

    if (XLEN == FETCH_XLEN) begin : g_pack_native
        assign w_push_entry = EW'(pack_entry(w_tag_pc, bus.imem_rsp_data));
    end else begin : g_pack_generic
        assign w_push_entry = {w_tag_pc, bus.imem_rsp_data};
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.redirect),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_q_full),
        .empty_o (w_q_empty),
        .count_o (w_q_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = !w_q_empty;
    assign bus.if_instr       = w_head[XLEN-1:0];
    assign bus.if_pc          = w_head[EW-1:XLEN];
    assign bus.if_pcplus4     = w_q_empty ? '0 : w_head[EW-1:XLEN] + XLEN'(4);

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_prefetch_unit : scoreboard bench with in-order memory     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_fetch_prefetch_unit;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mem_req_t    mem_q[$];
    exp_t        exp_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, rel_cyc = 0, first_valid_cyc = -1;
    int          accepts = 0, pops = 0, pops_total = 0;
    int          lat_min = 1, lat_max = 1, ready_pct = 100, ifready_pct = 100;
    logic        rst_knob = 1'b1, redir_knob = 1'b0;
    logic [31:0] redir_target = '0, exp_next_pc = '0;
    logic [31:0] first_pop_pc = '0, first_pop_pc4 = '0;
    logic [31:0] exp_fetch = '0;
    logic        prev_stall = 1'b0;

    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: drive inputs at the falling edge, then record the handshakes
    task automatic cycle();
        @(negedge clk);
        cyc++;
        rst                = rst_knob;
        bus.redirect       = redir_knob;
        bus.redirect_pc    = redir_target;
        bus.imem_req_ready = ($urandom_range(99) < 32'(ready_pct));
        bus.if_ready       = ($urandom_range(99) < 32'(ifready_pct));
        if (!rst_knob && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = f_instr(mem_q[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        if (rst_knob) begin
            mem_q.delete();
            exp_q.delete();
            exp_next_pc = 32'h0;
            accepts     = 0;
        end else begin
            if (bus.imem_rsp_valid) void'(mem_q.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mem_q.push_back('{bus.imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
                accepts++;
            end
            if (redir_knob) begin
                exp_q.delete();
                exp_next_pc = redir_target & ~32'h3;
            end
        end
        while (exp_q.size() < 16) begin
            exp_q.push_back('{exp_next_pc, f_instr(exp_next_pc)});
            exp_next_pc += 32'h4;
        end
    endtask

    task automatic do_reset();
        rst_knob = 1'b1;
        repeat (2) cycle();
        check("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
        check("rst_if_instr", bus.if_instr, 32'h0);
        check("rst_if_pc", bus.if_pc, 32'h0);
        check("rst_if_pcplus4", bus.if_pcplus4, 32'h0);
        rst_knob        = 1'b0;
        rel_cyc         = cyc + 1;
        first_valid_cyc = -1;
        pops            = 0;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redir_knob   = 1'b1;
        redir_target = target;
        cycle();
        redir_knob   = 1'b0;
        pops         = 0;
    endtask

    // monitor: compares every decode handshake and request against the model
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
                exp_fetch  = 32'h0;
                prev_stall = 1'b0;
            end else if (bus.redirect) begin
                check("redirect_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
                exp_fetch  = bus.redirect_pc & ~32'h3;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("req_hold_valid", {31'b0, bus.imem_req_valid}, 32'h1);
                if (bus.imem_req_valid) begin
                    check("req_addr", bus.imem_req_addr, exp_fetch);
                    if (bus.imem_req_ready) exp_fetch += 32'h4;
                    prev_stall = !bus.imem_req_ready;
                end else begin
                    prev_stall = 1'b0;
                end
                if (bus.if_valid && first_valid_cyc < 0) first_valid_cyc = cyc - rel_cyc + 1;
                if (bus.if_valid && bus.if_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pop_unexpected: got pc %h expected none", bus.if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("if_pc", bus.if_pc, e.pc);
                        check("if_instr", bus.if_instr, e.instr);
                        check("if_pcplus4", bus.if_pcplus4, e.pc + 32'h4);
                    end
                    if (pops == 0) begin
                        first_pop_pc  = bus.if_pc;
                        first_pop_pc4 = bus.if_pcplus4;
                    end
                    pops++;
                    pops_total++;
                end
                check("outstanding_le_max", {31'b0, mem_q.size() <= int'(MAX_OUT)}, 32'h1);
            end
        end
    end

    initial begin
        int p0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b0;

        // streaming with single-cycle memory
        lat_min = 1; lat_max = 1; ready_pct = 100; ifready_pct = 100;
        do_reset();
        repeat (20) cycle();
        #2;
        check("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        check("stream_pops", 32'(pops), 32'd18);

        // decode stall fills the queue and throttles requests
        do_reset();
        ifready_pct = 0;
        repeat (10) cycle();
        #2;
        check("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        check("stall_accepts", 32'(accepts), 32'd4);
        check("stall_if_valid", {31'b0, bus.if_valid}, 32'h1);
        ifready_pct = 100;
        repeat (8) cycle();
        #2;
        check("release_first_pc", first_pop_pc, 32'h0);

        // memory back-pressure holds the request
        do_reset();
        for (int i = 0; i < 20 && accepts < 4; i++) cycle();
        ready_pct = 0;
        repeat (5) begin
            cycle();
            check("hold_addr", bus.imem_req_addr, 32'h10);
            check("hold_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        end
        ready_pct = 100;
        cycle();
        cycle();
        check("after_hold_addr", bus.imem_req_addr, 32'h14);

        // redirect with two requests in flight
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) cycle();
        redirect_to(32'h103);
        repeat (15) cycle();
        #2;
        check("redir_first_pc", first_pop_pc, 32'h100);

        // redirect coinciding with a response
        lat_min = 2; lat_max = 2;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) break;
        end
        redirect_to(32'h2000);
        repeat (15) cycle();
        #2;
        check("redir_rsp_first_pc", first_pop_pc, 32'h2000);

        // address wrap at the top of memory
        lat_min = 1; lat_max = 1;
        redirect_to(32'hFFFF_FFFC);
        repeat (10) cycle();
        #2;
        check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFFC);
        check("wrap_pcplus4", first_pop_pc4, 32'h0);

        // randomized traffic with redirects and occasional resets
        lat_min = 1; lat_max = 4; ready_pct = 70; ifready_pct = 70;
        do_reset();
        p0 = pops_total;
        for (int i = 0; i < 3000; i++) begin
            redir_knob   = ($urandom_range(99) < 3);
            redir_target = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                    : ($urandom & 32'h0000_FFFF);
            rst_knob     = ($urandom_range(999) < 2);
            cycle();
        end
        redir_knob = 1'b0;
        rst_knob   = 1'b0;
        repeat (3) cycle();
        #2;
        check("random_progress", {31'b0, (pops_total - p0) > 300}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
